// File: rtl/speck_round_engine.sv
// Iterative Speck-style block cipher round engine: one cipher round and one
// key-schedule round per clock. Handshakes with the upstream control FSM via a
// level start request and returns eqz once all rounds are done, holding the
// ciphertext until the request drops.
module speck_round_engine #(
  parameter int W      = 32,
  parameter int ROUNDS = 27,
  parameter int ALPHA  = 8,
  parameter int BETA   = 3
) (
  input  logic           clk,
  input  logic           reset_1,
  input  logic           start_speck,
  input  logic [2*W-1:0] X,
  input  logic [2*W-1:0] K1,
  output logic           eqz,
  output logic           busy,
  output logic [2*W-1:0] ct
);

  localparam int RW = $clog2(ROUNDS + 1);
  localparam logic [RW-1:0] LAST_RND = RW'(ROUNDS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic           armed_q, armed_d;
  logic           eqz_q, eqz_d;
  logic           busy_q, busy_d;
  logic [2*W-1:0] ct_q, ct_d;
  logic [W-1:0]   x_q, x_d;
  logic [W-1:0]   y_q, y_d;
  logic [W-1:0]   k_q, k_d;
  logic [W-1:0]   l_q, l_d;
  logic [RW-1:0]  rnd_q, rnd_d;

  logic [W-1:0]   xRound, yRound, lRound, kRound;

  function automatic logic [W-1:0] ror(input logic [W-1:0] v, input int unsigned s);
    return (v >> s) | (v << (W - s));
  endfunction

  function automatic logic [W-1:0] rol(input logic [W-1:0] v, input int unsigned s);
    return (v << s) | (v >> (W - s));
  endfunction

  // The x update consumes the current round key k; the key schedule advances
  // in parallel so the next round sees the freshly derived key.
  assign xRound = (ror(x_q, ALPHA) + y_q) ^ k_q;
  assign yRound = rol(y_q, BETA) ^ xRound;
  assign lRound = (k_q + ror(l_q, ALPHA)) ^ W'(rnd_q);
  assign kRound = rol(k_q, BETA) ^ lRound;

  // Next-state logic: load on an armed start, iterate rounds, hold result until start drops.
  always_comb begin
    state_d = state_q;
    armed_d = armed_q;
    eqz_d   = eqz_q;
    busy_d  = busy_q;
    ct_d    = ct_q;
    x_d     = x_q;
    y_d     = y_q;
    k_d     = k_q;
    l_d     = l_q;
    rnd_d   = rnd_q;
    case (state_q)
      IDLE: begin
        if (start_speck && armed_q) begin
          x_d     = X[2*W-1:W];
          y_d     = X[W-1:0];
          k_d     = K1[W-1:0];
          l_d     = K1[2*W-1:W];
          rnd_d   = '0;
          armed_d = 1'b0;
          busy_d  = 1'b1;
          state_d = RUN;
        end else if (!start_speck) begin
          armed_d = 1'b1;
        end
      end
      RUN: begin
        x_d   = xRound;
        y_d   = yRound;
        k_d   = kRound;
        l_d   = lRound;
        rnd_d = rnd_q + RW'(1);
        if (rnd_q == LAST_RND) begin
          ct_d    = {xRound, yRound};
          eqz_d   = 1'b1;
          busy_d  = 1'b0;
          state_d = DONE;
        end
      end
      DONE: begin
        if (!start_speck) begin
          eqz_d   = 1'b0;
          armed_d = 1'b1;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers; a synchronous reset abandons any run in progress.
  always_ff @(posedge clk) begin
    if (reset_1) begin
      state_q <= IDLE;
      armed_q <= 1'b1;
      eqz_q   <= 1'b0;
      busy_q  <= 1'b0;
      ct_q    <= '0;
      x_q     <= '0;
      y_q     <= '0;
      k_q     <= '0;
      l_q     <= '0;
      rnd_q   <= '0;
    end else begin
      state_q <= state_d;
      armed_q <= armed_d;
      eqz_q   <= eqz_d;
      busy_q  <= busy_d;
      ct_q    <= ct_d;
      x_q     <= x_d;
      y_q     <= y_d;
      k_q     <= k_d;
      l_q     <= l_d;
      rnd_q   <= rnd_d;
    end
  end

  assign eqz  = eqz_q;
  assign busy = busy_q;
  assign ct   = ct_q;

endmodule

// File: tb/tb_speck_round_engine.sv
// Testbench for speck_round_engine: three instances (1, 3 and 27 rounds)
// driven by directed scenarios, checked against hand values and a small
// reference model of the cipher.
module tb_speck_round_engine;

  logic        clk;
  logic        reset_1;
  logic        start1, start3, start27;
  logic [63:0] X, K1;
  logic        eqz1, busy1, eqz3, busy3, eqz27, busy27;
  logic [63:0] ct1, ct3, ct27;

  int checks;
  int errors;

  speck_round_engine #(.ROUNDS(1)) dut1 (
    .clk(clk), .reset_1(reset_1), .start_speck(start1), .X(X), .K1(K1),
    .eqz(eqz1), .busy(busy1), .ct(ct1)
  );

  speck_round_engine #(.ROUNDS(3)) dut3 (
    .clk(clk), .reset_1(reset_1), .start_speck(start3), .X(X), .K1(K1),
    .eqz(eqz3), .busy(busy3), .ct(ct3)
  );

  speck_round_engine dut27 (
    .clk(clk), .reset_1(reset_1), .start_speck(start27), .X(X), .K1(K1),
    .eqz(eqz27), .busy(busy27), .ct(ct27)
  );

  // Free-running clock, period 10.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference Speck model, written with explicit bit-slice rotations.
  function automatic logic [63:0] speckRef(input logic [63:0] pt, input logic [63:0] key,
                                           input int rounds);
    logic [31:0] x, y, k, l, t;
    x = pt[63:32];
    y = pt[31:0];
    l = key[63:32];
    k = key[31:0];
    for (int i = 0; i < rounds; i++) begin
      t = {x[7:0], x[31:8]};
      x = (t + y) ^ k;
      y = {y[28:0], y[31:29]} ^ x;
      t = {l[7:0], l[31:8]};
      l = (k + t) ^ 32'(i);
      k = {k[28:0], k[31:29]} ^ l;
    end
    return {x, y};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_1 = 1'b1;
    tick();
    tick();
    checks++;
    if ({eqz1, busy1, eqz3, busy3, eqz27, busy27} !== 6'b0) begin
      errors++;
      $display("[TB] FAIL reset_flags got %b expected 000000", {eqz1, busy1, eqz3, busy3, eqz27, busy27});
    end
    checks++;
    if (ct1 !== 64'h0 || ct3 !== 64'h0 || ct27 !== 64'h0) begin
      errors++;
      $display("[TB] FAIL reset_ct got %h/%h/%h expected 0", ct1, ct3, ct27);
    end
    reset_1 = 1'b0;
    tick();
  endtask

  task automatic test_rounds1(input logic [63:0] pt, input logic [63:0] key,
                              input logic [63:0] expCt, input string name);
    X = pt;
    K1 = key;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    checks++;
    if (busy1 !== 1'b1 || eqz1 !== 1'b0) begin
      errors++;
      $display("[TB] FAIL %s_busy got busy=%b eqz=%b expected busy=1 eqz=0", name, busy1, eqz1);
    end
    tick();
    checks++;
    if (eqz1 !== 1'b1 || busy1 !== 1'b0) begin
      errors++;
      $display("[TB] FAIL %s_done got eqz=%b busy=%b expected eqz=1 busy=0", name, eqz1, busy1);
    end
    checks++;
    if (ct1 !== expCt) begin
      errors++;
      $display("[TB] FAIL %s_ct got %h expected %h", name, ct1, expCt);
    end
    tick();
    checks++;
    if (eqz1 !== 1'b0 || ct1 !== expCt) begin
      errors++;
      $display("[TB] FAIL %s_release got eqz=%b ct=%h expected eqz=0 ct=%h", name, eqz1, ct1, expCt);
    end
  endtask

  task automatic test_rounds3();
    int busyCycles;
    X = 64'h0;
    K1 = 64'h0;
    start3 = 1'b1;
    tick();
    start3 = 1'b0;
    busyCycles = 0;
    for (int i = 0; i < 3; i++) begin
      if (busy3 === 1'b1) busyCycles++;
      checks++;
      if (eqz3 !== 1'b0) begin
        errors++;
        $display("[TB] FAIL r3_early_eqz cycle %0d got eqz=%b expected 0", i, eqz3);
      end
      tick();
    end
    checks++;
    if (busyCycles != 3) begin
      errors++;
      $display("[TB] FAIL r3_busy_cycles got %0d expected 3", busyCycles);
    end
    checks++;
    if (eqz3 !== 1'b1 || busy3 !== 1'b0) begin
      errors++;
      $display("[TB] FAIL r3_done got eqz=%b busy=%b expected eqz=1 busy=0", eqz3, busy3);
    end
    checks++;
    if (ct3 !== 64'h00000001_00000001) begin
      errors++;
      $display("[TB] FAIL r3_ct got %h expected 0000000100000001", ct3);
    end
    tick();
  endtask

  task automatic test_held_start();
    int cycles;
    int unstable;
    logic [63:0] expCt;
    X = 64'h6c617669_75716520;
    K1 = 64'h0f0e0d0c_0b0a0908;
    expCt = speckRef(X, K1, 27);
    start27 = 1'b1;
    tick();
    X = 64'h0;
    K1 = 64'h0;
    cycles = 0;
    while (eqz27 !== 1'b1 && cycles < 40) begin
      tick();
      cycles++;
    end
    checks++;
    if (cycles != 27) begin
      errors++;
      $display("[TB] FAIL held_latency got %0d expected 27", cycles);
    end
    checks++;
    if (ct27 !== expCt) begin
      errors++;
      $display("[TB] FAIL held_ct got %h expected %h", ct27, expCt);
    end
    unstable = 0;
    for (int i = 0; i < 120; i++) begin
      tick();
      if (eqz27 !== 1'b1 || busy27 !== 1'b0 || ct27 !== expCt) unstable++;
    end
    checks++;
    if (unstable != 0) begin
      errors++;
      $display("[TB] FAIL held_stable got %0d bad cycles expected 0", unstable);
    end
  endtask

  task automatic test_reset_midrun();
    int cycles;
    logic [63:0] expCt;
    start27 = 1'b0;
    tick();
    X = 64'h01234567_89abcdef;
    K1 = 64'hfedcba98_76543210;
    start27 = 1'b1;
    tick();
    for (int i = 0; i < 10; i++) tick();
    reset_1 = 1'b1;
    tick();
    checks++;
    if (eqz27 !== 1'b0 || busy27 !== 1'b0 || ct27 !== 64'h0) begin
      errors++;
      $display("[TB] FAIL midrun_reset got eqz=%b busy=%b ct=%h expected 0/0/0", eqz27, busy27, ct27);
    end
    reset_1 = 1'b0;
    X = 64'h11112222_33334444;
    K1 = 64'h55556666_77778888;
    expCt = speckRef(X, K1, 27);
    tick();
    checks++;
    if (busy27 !== 1'b1) begin
      errors++;
      $display("[TB] FAIL restart_busy got %b expected 1", busy27);
    end
    cycles = 0;
    while (eqz27 !== 1'b1 && cycles < 40) begin
      tick();
      cycles++;
    end
    checks++;
    if (cycles != 27 || ct27 !== expCt) begin
      errors++;
      $display("[TB] FAIL restart_run got %0d cycles ct=%h expected 27 cycles ct=%h", cycles, ct27, expCt);
    end
  endtask

  task automatic test_back_to_back();
    int cycles;
    logic [63:0] oldCt, expCt;
    oldCt = ct27;
    start27 = 1'b0;
    tick();
    checks++;
    if (eqz27 !== 1'b0 || ct27 !== oldCt) begin
      errors++;
      $display("[TB] FAIL drop_idle got eqz=%b ct=%h expected eqz=0 ct=%h", eqz27, ct27, oldCt);
    end
    X = 64'hdeadbeef_cafef00d;
    K1 = 64'h0badc0de_12345678;
    expCt = speckRef(X, K1, 27);
    start27 = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) tick();
    X = 64'hffffffff_ffffffff;
    K1 = 64'h0;
    cycles = 5;
    while (eqz27 !== 1'b1 && cycles < 40) begin
      tick();
      cycles++;
    end
    checks++;
    if (cycles != 27) begin
      errors++;
      $display("[TB] FAIL b2b_latency got %0d expected 27", cycles);
    end
    checks++;
    if (ct27 !== expCt) begin
      errors++;
      $display("[TB] FAIL b2b_ct got %h expected %h", ct27, expCt);
    end
    start27 = 1'b0;
    tick();
  endtask

  // Scenario sequence.
  initial begin
    checks  = 0;
    errors  = 0;
    reset_1 = 1'b1;
    start1  = 1'b0;
    start3  = 1'b0;
    start27 = 1'b0;
    X       = 64'h0;
    K1      = 64'h0;
    test_reset();
    test_rounds1(64'h00000001_00000000, 64'h0, 64'h01000000_01000000, "r1_zero_key");
    test_rounds1(64'h00000001_00000000, 64'h00000000_00000005, 64'h01000005_01000005, "r1_key5");
    test_rounds3();
    test_held_start();
    test_reset_midrun();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
